// File: rtl/vol_buffer_arbiter.sv
// Ping-pong volume buffer arbiter.
// Two banks alternate between acquisition (writer) and software transfer
// (reader). Status, a volume counter and a drop counter are exposed through
// a small zero-wait-state Avalon-MM slave.
module vol_buffer_arbiter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vol_start,
    input  logic        vol_end,
    input  logic        vol_transfer_done,
    output logic        wr_bank,
    output logic        wr_enable,
    output logic        rd_bank,
    output logic        vol_ready,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata
);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_e;

    typedef enum logic {
        A_IDLE = 1'b0,
        A_FILL = 1'b1
    } acq_state_e;

    // Architectural state
    acq_state_e         acq_q, acq_d;
    bank_state_e        bank_q [2];
    bank_state_e        bank_d [2];
    logic               wr_bank_q, wr_bank_d;
    logic               rd_bank_q, rd_bank_d;
    logic               vol_ready_q, vol_ready_d;
    logic               done_q;
    logic [CNT_W-1:0]   vol_cnt_q, vol_cnt_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic               overflow_q, overflow_d;
    logic               spurious_q, spurious_d;
    logic               proto_err_q, proto_err_d;

    // Per-cycle events derived from the pre-edge state
    logic               done_edge;
    logic               vol_evt;
    logic               drop_evt;
    logic               ovf_set;
    logic               spur_set;
    logic               perr_set;

    // Avalon write decode
    logic               wr_acc;
    logic               clr_flags;
    logic               clr_vol;
    logic               clr_drop;
    logic               unused_wdata;

    // Rising edge of the software transfer-done level
    always_comb begin
        done_edge = vol_transfer_done & ~done_q;
    end

    // Acquisition FSM and read-side release, both decided on pre-edge state.
    // The writer only touches a bank that is EMPTY or FILLING and the reader
    // only touches a FULL bank, so both may update bank_d in the same cycle.
    always_comb begin
        acq_d     = acq_q;
        bank_d    = bank_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        vol_evt   = 1'b0;
        drop_evt  = 1'b0;
        ovf_set   = 1'b0;
        spur_set  = 1'b0;
        perr_set  = 1'b0;

        case (acq_q)
            A_IDLE: begin
                if (vol_start) begin
                    if (bank_q[wr_bank_q] == EMPTY) begin
                        bank_d[wr_bank_q] = FILLING;
                        acq_d             = A_FILL;
                    end else begin
                        drop_evt = 1'b1;
                        ovf_set  = 1'b1;
                    end
                end
                if (vol_end) begin
                    perr_set = 1'b1;
                end
            end
            A_FILL: begin
                if (vol_end) begin
                    bank_d[wr_bank_q] = FULL;
                    wr_bank_d         = ~wr_bank_q;
                    vol_evt           = 1'b1;
                    acq_d             = A_IDLE;
                end
                if (vol_start) begin
                    perr_set = 1'b1;
                end
            end
        endcase

        if (done_edge) begin
            if (bank_q[rd_bank_q] == FULL) begin
                bank_d[rd_bank_q] = EMPTY;
                rd_bank_d         = ~rd_bank_q;
            end else begin
                spur_set = 1'b1;
            end
        end

        vol_ready_d = (bank_d[rd_bank_d] == FULL);
    end

    // Register-interface write decode
    always_comb begin
        wr_acc       = chipselect & ~write_n;
        clr_flags    = wr_acc && (address == 2'd0);
        clr_vol      = wr_acc && (address == 2'd1);
        clr_drop     = wr_acc && (address == 2'd2);
        unused_wdata = ^{writedata[31:5], writedata[1:0]};
    end

    // Counters: a clear coinciding with an event leaves the count at one
    always_comb begin
        vol_cnt_d  = vol_cnt_q;
        drop_cnt_d = drop_cnt_q;

        if (clr_vol) begin
            vol_cnt_d = vol_evt ? CNT_W'(1) : '0;
        end else if (vol_evt) begin
            vol_cnt_d = vol_cnt_q + CNT_W'(1);
        end

        if (clr_drop) begin
            drop_cnt_d = drop_evt ? CNT_W'(1) : '0;
        end else if (drop_evt && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    // Sticky flags: a set wins over a simultaneous write-one-to-clear
    always_comb begin
        overflow_d  = (overflow_q  & ~(clr_flags & writedata[2])) | ovf_set;
        spurious_d  = (spurious_q  & ~(clr_flags & writedata[3])) | spur_set;
        proto_err_d = (proto_err_q & ~(clr_flags & writedata[4])) | perr_set;
    end

    // FSM, bank and pointer state registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acq_q       <= A_IDLE;
            bank_q[0]   <= EMPTY;
            bank_q[1]   <= EMPTY;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            vol_ready_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            acq_q       <= acq_d;
            bank_q[0]   <= bank_d[0];
            bank_q[1]   <= bank_d[1];
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            vol_ready_q <= vol_ready_d;
            done_q      <= vol_transfer_done;
        end
    end

    // Counter and sticky-flag registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vol_cnt_q   <= '0;
            drop_cnt_q  <= '0;
            overflow_q  <= 1'b0;
            spurious_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            vol_cnt_q   <= vol_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            overflow_q  <= overflow_d;
            spurious_q  <= spurious_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Output mapping
    always_comb begin
        wr_bank   = wr_bank_q;
        wr_enable = (acq_q == A_FILL);
        rd_bank   = rd_bank_q;
        vol_ready = vol_ready_q;
    end

    // Combinational register read-back
    always_comb begin
        readdata = '0;
        case (address)
            2'd0: readdata[5:0] = {rd_bank_q, proto_err_q, spurious_q,
                                   overflow_q, wr_bank_q, vol_ready_q};
            2'd1: readdata[CNT_W-1:0] = vol_cnt_q;
            2'd2: readdata[CNT_W-1:0] = drop_cnt_q;
            default: readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_vol_buffer_arbiter.sv
// Self-checking bench for vol_buffer_arbiter: directed scenarios plus a
// random phase, all checked against a behavioural model via a scoreboard.
module tb_vol_buffer_arbiter;

    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        reset_n, vol_start, vol_end, vol_transfer_done;
    logic        wr_bank, wr_enable, rd_bank, vol_ready;
    logic [1:0]  address;
    logic        chipselect, write_n;
    logic [31:0] writedata, readdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    vol_buffer_arbiter #(.CNT_W(CW)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .vol_start         (vol_start),
        .vol_end           (vol_end),
        .vol_transfer_done (vol_transfer_done),
        .wr_bank           (wr_bank),
        .wr_enable         (wr_enable),
        .rd_bank           (rd_bank),
        .vol_ready         (vol_ready),
        .address           (address),
        .chipselect        (chipselect),
        .write_n           (write_n),
        .writedata         (writedata),
        .readdata          (readdata)
    );

    typedef struct {
        logic        wr_bank;
        logic        wr_enable;
        logic        rd_bank;
        logic        vol_ready;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];

    // Behavioural model state (bank: 0 empty, 1 filling, 2 full)
    int m_bank [2];
    bit m_fill, m_wr, m_rd, m_ready, m_done, m_ovf, m_spur, m_perr;
    int m_vcnt, m_dcnt;
    bit td_lvl = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [1:0] a);
        case (a)
            2'd0:    return {26'd0, m_rd, m_perr, m_spur, m_ovf, m_wr, m_ready};
            2'd1:    return 32'(m_vcnt);
            2'd2:    return 32'(m_dcnt);
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step(input bit rst, input bit st, input bit en, input bit td,
                              input bit wacc, input logic [1:0] a, input logic [31:0] wd);
        int  nb [2];
        bit  nfill, nwr, nrd, edge_ev, vev, dev, so, ss, sp;
        int  maxc;
        maxc = (1 << CW) - 1;
        if (!rst) begin
            m_bank[0] = 0; m_bank[1] = 0;
            m_fill = 0; m_wr = 0; m_rd = 0; m_ready = 0; m_done = 0;
            m_ovf = 0; m_spur = 0; m_perr = 0; m_vcnt = 0; m_dcnt = 0;
            return;
        end
        nb[0] = m_bank[0]; nb[1] = m_bank[1];
        nfill = m_fill; nwr = m_wr; nrd = m_rd;
        vev = 0; dev = 0; so = 0; ss = 0; sp = 0;
        edge_ev = td && !m_done;
        if (!m_fill) begin
            if (st) begin
                if (m_bank[m_wr] == 0) begin nb[m_wr] = 1; nfill = 1; end
                else begin dev = 1; so = 1; end
            end
            if (en) sp = 1;
        end else begin
            if (en) begin nb[m_wr] = 2; nwr = !m_wr; vev = 1; nfill = 0; end
            if (st) sp = 1;
        end
        if (edge_ev) begin
            if (m_bank[m_rd] == 2) begin nb[m_rd] = 0; nrd = !m_rd; end
            else ss = 1;
        end
        if (wacc && a == 2'd1) m_vcnt = vev ? 1 : 0;
        else if (vev)          m_vcnt = (m_vcnt + 1) % (1 << CW);
        if (wacc && a == 2'd2) m_dcnt = dev ? 1 : 0;
        else if (dev && m_dcnt < maxc) m_dcnt = m_dcnt + 1;
        if (wacc && a == 2'd0) begin
            if (wd[2]) m_ovf  = 0;
            if (wd[3]) m_spur = 0;
            if (wd[4]) m_perr = 0;
        end
        m_ovf  = m_ovf  | so;
        m_spur = m_spur | ss;
        m_perr = m_perr | sp;
        m_bank[0] = nb[0]; m_bank[1] = nb[1];
        m_fill = nfill; m_wr = nwr; m_rd = nrd;
        m_ready = (m_bank[m_rd] == 2);
        m_done = td;
    endtask

    // One clock: drive at negedge, push the model's prediction, return #1 after posedge
    task automatic cyc(input bit rst, input bit st, input bit en, input bit td,
                       input bit cs, input bit wn, input logic [1:0] a, input logic [31:0] wd);
        exp_t e;
        @(negedge clk);
        reset_n = rst; vol_start = st; vol_end = en; vol_transfer_done = td;
        chipselect = cs; write_n = wn; address = a; writedata = wd;
        model_step(rst, st, en, td, cs && !wn, a, wd);
        e.wr_bank = m_wr; e.wr_enable = m_fill; e.rd_bank = m_rd;
        e.vol_ready = m_ready; e.rdata = model_rd(a);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit st, input bit en);
        cyc(1'b1, st, en, td_lvl, 1'b0, 1'b1, 2'd0, 32'd0);
    endtask

    task automatic peek(input logic [1:0] a);
        cyc(1'b1, 1'b0, 1'b0, td_lvl, 1'b0, 1'b1, a, 32'd0);
    endtask

    task automatic poke(input logic [1:0] a, input logic [31:0] d);
        cyc(1'b1, 1'b0, 1'b0, td_lvl, 1'b1, 1'b0, a, d);
    endtask

    task automatic set_td(input bit b);
        td_lvl = b;
        cyc(1'b1, 1'b0, 1'b0, b, 1'b0, 1'b1, 2'd0, 32'd0);
    endtask

    task automatic do_reset(input int n);
        td_lvl = 1'b0;
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'd0);
    endtask

    // Scoreboard monitor: pop one prediction per clock and compare
    initial begin : sb_mon
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_eq("sb_wr_bank",   32'(wr_bank),   32'(e.wr_bank));
                check_eq("sb_wr_enable", 32'(wr_enable), 32'(e.wr_enable));
                check_eq("sb_rd_bank",   32'(rd_bank),   32'(e.rd_bank));
                check_eq("sb_vol_ready", 32'(vol_ready), 32'(e.vol_ready));
                check_eq("sb_readdata",  readdata,       e.rdata);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int en_cnt;
        bit rst, st, en, cs, wn;
        logic [1:0]  a;
        logic [31:0] wd;

        // Reset state
        do_reset(2);
        check_eq("rst_wr_enable", 32'(wr_enable), 32'd0);
        check_eq("rst_wr_bank",   32'(wr_bank),   32'd0);
        check_eq("rst_rd_bank",   32'(rd_bank),   32'd0);
        check_eq("rst_vol_ready", 32'(vol_ready), 32'd0);
        peek(2'd0);
        check_eq("rst_status", readdata, 32'd0);

        // Single volume, start and end ten cycles apart
        pulse(1'b1, 1'b0);
        en_cnt = int'(wr_enable);
        repeat (9) begin
            pulse(1'b0, 1'b0);
            en_cnt += int'(wr_enable);
        end
        pulse(1'b0, 1'b1);
        en_cnt += int'(wr_enable);
        check_eq("a_wren_cycles", 32'(en_cnt), 32'd10);
        check_eq("a_vol_ready",   32'(vol_ready), 32'd1);
        check_eq("a_rd_bank",     32'(rd_bank),   32'd0);
        check_eq("a_wr_bank",     32'(wr_bank),   32'd1);
        peek(2'd1);
        check_eq("a_vol_cnt", readdata, 32'd1);

        // Transfer-done held high for five cycles releases exactly one bank
        set_td(1'b1);
        check_eq("c_vol_ready", 32'(vol_ready), 32'd0);
        check_eq("c_rd_bank",   32'(rd_bank),   32'd1);
        repeat (4) set_td(1'b1);
        check_eq("c_rd_bank_held", 32'(rd_bank), 32'd1);
        peek(2'd0);
        check_eq("c_status", readdata, 32'h22);
        set_td(1'b0);

        // Spurious transfer-done, then write-one-to-clear
        set_td(1'b1);
        check_eq("d_rd_bank", 32'(rd_bank), 32'd1);
        peek(2'd0);
        check_eq("d_status_spur", readdata, 32'h2A);
        poke(2'd0, 32'h08);
        check_eq("d_status_clr", readdata, 32'h22);
        set_td(1'b0);

        // Fill both banks, third start is dropped
        pulse(1'b1, 1'b0); pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0); pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        check_eq("b_wr_enable", 32'(wr_enable), 32'd0);
        check_eq("b_vol_ready", 32'(vol_ready), 32'd1);
        peek(2'd2);
        check_eq("b_drop_cnt", readdata, 32'd1);
        peek(2'd0);
        check_eq("b_status", readdata, 32'h27);

        // vol_end of bank1 coincides with the release of bank0
        set_td(1'b1);
        set_td(1'b0);
        pulse(1'b1, 1'b0);
        check_eq("e_wr_enable_fill", 32'(wr_enable), 32'd1);
        td_lvl = 1'b1;
        pulse(1'b0, 1'b1);
        check_eq("e_rd_bank",   32'(rd_bank),   32'd1);
        check_eq("e_vol_ready", 32'(vol_ready), 32'd1);
        check_eq("e_wr_bank",   32'(wr_bank),   32'd0);
        td_lvl = 1'b0;
        pulse(1'b1, 1'b0);
        check_eq("e_bank0_empty", 32'(wr_enable), 32'd1);

        // Reset while filling, then a stray vol_end
        do_reset(1);
        check_eq("f_wr_enable", 32'(wr_enable), 32'd0);
        check_eq("f_wr_bank",   32'(wr_bank),   32'd0);
        check_eq("f_rd_bank",   32'(rd_bank),   32'd0);
        check_eq("f_vol_ready", 32'(vol_ready), 32'd0);
        pulse(1'b0, 1'b1);
        peek(2'd0);
        check_eq("f_status_perr", readdata, 32'h10);

        // Volume counter wraps modulo 2^CW
        do_reset(1);
        repeat (16) begin
            pulse(1'b1, 1'b0); pulse(1'b0, 1'b1);
            set_td(1'b1); set_td(1'b0);
        end
        peek(2'd1);
        check_eq("g_vol_cnt_wrap", readdata, 32'd0);

        // Drop counter saturates; clear with event gives one; set beats clear
        pulse(1'b1, 1'b0); pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0); pulse(1'b0, 1'b1);
        repeat (16) pulse(1'b1, 1'b0);
        peek(2'd2);
        check_eq("h_drop_sat", readdata, 32'd15);
        cyc(1'b1, 1'b1, 1'b0, td_lvl, 1'b1, 1'b0, 2'd2, 32'd0);
        check_eq("h_drop_clr_evt", readdata, 32'd1);
        cyc(1'b1, 1'b1, 1'b0, td_lvl, 1'b1, 1'b0, 2'd0, 32'h04);
        check_eq("h_ovf_set_wins", 32'(readdata[2]), 32'd1);

        // Random phase, scoreboard only
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 59) != 0);
            st  = ($urandom_range(0, 3) == 0);
            en  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) td_lvl = !td_lvl;
            cs  = ($urandom_range(0, 3) == 0);
            wn  = ($urandom_range(0, 1) == 0);
            a   = 2'($urandom_range(0, 3));
            wd  = $urandom;
            cyc(rst, st, en, td_lvl, cs, wn, a, wd);
        end

        @(posedge clk);
        #2;
        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
